// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the 7-segment scan driver.
// Holds the active-low glyph table (segment order a,b,c,d,e,f,g in bits [6:0])
// and seg_decode(), which maps a nibble plus hex-mode flag to a glyph.
package ssd_pkg;

    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_0     = 7'b0000001;
    localparam glyph_t GLYPH_1     = 7'b1001111;
    localparam glyph_t GLYPH_2     = 7'b0010010;
    localparam glyph_t GLYPH_3     = 7'b0000110;
    localparam glyph_t GLYPH_4     = 7'b1001100;
    localparam glyph_t GLYPH_5     = 7'b0100100;
    localparam glyph_t GLYPH_6     = 7'b0100000;
    localparam glyph_t GLYPH_7     = 7'b0001111;
    localparam glyph_t GLYPH_8     = 7'b0000000;
    localparam glyph_t GLYPH_9     = 7'b0000100;
    localparam glyph_t GLYPH_A     = 7'b0001000;
    localparam glyph_t GLYPH_B     = 7'b1100000;
    localparam glyph_t GLYPH_C     = 7'b0110001;
    localparam glyph_t GLYPH_D     = 7'b1000010;
    localparam glyph_t GLYPH_E     = 7'b0110000;
    localparam glyph_t GLYPH_F     = 7'b0111000;
    localparam glyph_t GLYPH_BLANK = 7'h7F;

    // Values 10..15 only have a glyph in hex mode; otherwise they show nothing.
    function automatic glyph_t seg_decode(input logic [3:0] nibble, input logic hex_mode);
        glyph_t g;
        case (nibble)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = hex_mode ? GLYPH_A : GLYPH_BLANK;
            4'hB:    g = hex_mode ? GLYPH_B : GLYPH_BLANK;
            4'hC:    g = hex_mode ? GLYPH_C : GLYPH_BLANK;
            4'hD:    g = hex_mode ? GLYPH_D : GLYPH_BLANK;
            4'hE:    g = hex_mode ? GLYPH_E : GLYPH_BLANK;
            4'hF:    g = hex_mode ? GLYPH_F : GLYPH_BLANK;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// ssd_glyph_decode: combinational nibble -> active-low 7-segment glyph.
// Ports:
//   nibble    in   4  value to display
//   hex_mode  in   1  1 = show 10..15 as A b C d E F, 0 = blank them
//   glyph     out  7  active-low segments [6:0] = a..g
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output glyph_t     glyph
);

    always_comb begin
        glyph = seg_decode(nibble, hex_mode);
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed driver for an N-digit common-anode 7-segment display.
// Digits are scanned leftmost (NUM_DIGITS-1) to rightmost (0), SLOT_CYCLES clocks each,
// with the first BLANK_CYCLES of every slot dark on all anodes to avoid ghosting.
// Display inputs are captured once per frame, so a frame never mixes old and new data.
// Optional feature macro: SSD_BLINK_EN adds blink_i and a frame counter that hides
// blinking digits for BLINK_FRAMES frames out of every 2*BLINK_FRAMES.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   digits_i   in   nibble k = digits_i[4k+3:4k], k = NUM_DIGITS-1 is leftmost
//   dp_i       in   per-digit decimal point request
//   en_i       in   0 = display dark (scan keeps running)
//   hex_mode_i in   1 = show A..F, 0 = blank 10..15
//   lzb_i      in   1 = blank leading zeros
//   blink_i    in   per-digit blink enable (SSD_BLINK_EN only)
//   anode_o    out  active-low one-hot digit enable
//   seg_o      out  active-low segments a..g in [6:0]
//   dp_o       out  active-low decimal point
//   frame_o    out  one-cycle pulse at each frame start
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 32768,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    en_i,
    input  logic                    hex_mode_i,
    input  logic                    lzb_i,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_i,
`endif
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Slot prescaler and digit index
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cnt_wrap;
    logic             frame_start;

    assign cnt_wrap    = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    // True in the first cycle after reset as well, since that is the reset state.
    assign frame_start = (idx_q == IDX_W'(NUM_DIGITS - 1)) && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= IDX_W'(NUM_DIGITS - 1);
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Per-frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic                    snap_hex_q;
    logic                    snap_lzb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_hex_q    <= 1'b0;
            snap_lzb_q    <= 1'b0;
        end else if (frame_start) begin
            snap_digits_q <= digits_i;
            snap_dp_q     <= dp_i;
            snap_hex_q    <= hex_mode_i;
            snap_lzb_q    <= lzb_i;
        end
    end

    // The first slot of a frame is decoded from the values being captured, so the
    // frame's first output already reflects the new snapshot.
    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic                    eff_hex;
    logic                    eff_lzb;

    assign eff_digits = frame_start ? digits_i   : snap_digits_q;
    assign eff_dp     = frame_start ? dp_i       : snap_dp_q;
    assign eff_hex    = frame_start ? hex_mode_i : snap_hex_q;
    assign eff_lzb    = frame_start ? lzb_i      : snap_lzb_q;

    // Blink phase
    logic blink_hide;

`ifdef SSD_BLINK_EN
    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FCNT_W-1:0]     fcnt_q;
    logic                  phase_q;
    logic [NUM_DIGITS-1:0] snap_blink_q;
    logic                  snap_off_q;
    logic [NUM_DIGITS-1:0] eff_blink;
    logic                  eff_off;

    // A frame uses the phase in force when it starts; the toggle lands afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q       <= '0;
            phase_q      <= 1'b1;
            snap_blink_q <= '0;
            snap_off_q   <= 1'b0;
        end else if (frame_start) begin
            snap_blink_q <= blink_i;
            snap_off_q   <= ~phase_q;
            if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                fcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign eff_blink  = frame_start ? blink_i : snap_blink_q;
    assign eff_off    = frame_start ? ~phase_q : snap_off_q;
    assign blink_hide = eff_off & eff_blink[idx_q];
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_FRAMES;
    assign blink_hide       = 1'b0;
`endif

    // Leading-zero mask: bit k set when nibbles k..NUM_DIGITS-1 are all zero (k > 0).
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (eff_digits[4*k +: 4] == 4'h0);
            if (k > 0) begin
                lz_mask[k] = zero_run;
            end
        end
    end

    // Current digit decode
    logic [3:0] cur_nibble;
    glyph_t     cur_glyph;

    assign cur_nibble = eff_digits[int'(idx_q)*4 +: 4];

    ssd_glyph_decode u_glyph (
        .nibble   (cur_nibble),
        .hex_mode (eff_hex),
        .glyph    (cur_glyph)
    );

    // Output next-state
    logic [NUM_DIGITS-1:0] anode_d;
    glyph_t                seg_d;
    logic                  dp_d;
    logic                  blanked;
    logic                  in_blank;

    assign blanked  = eff_lzb & lz_mask[idx_q];
    assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));

    always_comb begin
        anode_d = '1;
        seg_d   = GLYPH_BLANK;
        dp_d    = 1'b1;
        if (en_i) begin
            if (!blanked) begin
                seg_d = cur_glyph;
                dp_d  = ~eff_dp[idx_q];
            end
            // A blanked digit keeps its anode on; only dead time and blink turn it off.
            if (!in_blank && !blink_hide) begin
                anode_d[idx_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_o <= '1;
            seg_o   <= GLYPH_BLANK;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            anode_o <= anode_d;
            seg_o   <= seg_d;
            dp_o    <= dp_d;
            frame_o <= frame_start;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Testbench for ssd_scan_mux (NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2).
// Expected outputs come from a timeline model: output edge e after reset release shows
// scan position (e-1) mod (N*S); a scoreboard queue decouples stimulus from checking.
module tb_ssd_scan_mux;

    localparam int unsigned N     = 4;
    localparam int unsigned S     = 8;
    localparam int unsigned B     = 2;
    localparam int unsigned BF    = 2;
    localparam int unsigned FRAME = N * S;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*N-1:0] digits_i = '0;
    logic [N-1:0]   dp_i = '0;
    logic           en_i = 1'b1;
    logic           hex_mode_i = 1'b0;
    logic           lzb_i = 1'b0;
    logic [N-1:0]   blink_i = '0;
    logic [N-1:0]   anode_o;
    logic [6:0]     seg_o;
    logic           dp_o;
    logic           frame_o;

    always #5 clk = ~clk;

    ssd_scan_mux #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (S),
        .BLANK_CYCLES (B),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_i   (digits_i),
        .dp_i       (dp_i),
        .en_i       (en_i),
        .hex_mode_i (hex_mode_i),
        .lzb_i      (lzb_i),
`ifdef SSD_BLINK_EN
        .blink_i    (blink_i),
`endif
        .anode_o    (anode_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .frame_o    (frame_o)
    );

    typedef struct {
        int           edge_no;
        logic [N-1:0] anode;
        logic [6:0]   seg;
        logic         dp;
        logic         frame;
    } out_t;

    out_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   pushes = 0;
    int   pops = 0;
    int   edge_n = 0;

    // Frame snapshot held by the model
    logic [4*N-1:0] s_digits;
    logic [N-1:0]   s_dp;
    logic           s_hex;
    logic           s_lzb;
    logic [N-1:0]   s_blink;

    // Glyphs 0..F, a..g in [6:0], active low
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] ref_glyph(input int v, input logic hex);
        if (v < 10 || hex) return GLYPH_TBL[v];
        return 7'h7F;
    endfunction

    // Predict the outputs of the next clock edge from the inputs currently applied.
    task automatic push_expected();
        int   p, idx, cnt, fr, nib;
        logic dark, blanked, hide;
        out_t o;
        edge_n++;
        p   = (edge_n - 1) % FRAME;
        idx = N - 1 - p / S;
        cnt = p % S;
        fr  = (edge_n - 1) / FRAME;
        if (p == 0) begin
            s_digits = digits_i;
            s_dp     = dp_i;
            s_hex    = hex_mode_i;
            s_lzb    = lzb_i;
            s_blink  = blink_i;
        end
        dark    = !en_i;
        blanked = s_lzb && (idx > 0) && ((s_digits >> (4 * idx)) == 0);
        hide    = 1'b0;
`ifdef SSD_BLINK_EN
        hide = ((fr / BF) % 2 == 1) && s_blink[idx];
`endif
        nib       = int'(s_digits[4*idx +: 4]);
        o.edge_no = edge_n;
        o.anode   = '1;
        if (!dark && cnt >= B && !hide) o.anode[idx] = 1'b0;
        o.seg   = (dark || blanked) ? 7'h7F : ref_glyph(nib, s_hex);
        o.dp    = (dark || blanked) ? 1'b1 : ~s_dp[idx];
        o.frame = (p == 0);
        exp_q.push_back(o);
        pushes++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            push_expected();
            @(negedge clk);
        end
    endtask

    task automatic check_reset(input string name);
        total++;
        if (anode_o !== '1 || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
            bad++;
            $display("FAIL %s: got anode=%b seg=%b dp=%b frame=%b, want anode=1111 seg=1111111 dp=1 frame=0",
                     name, anode_o, seg_o, dp_o, frame_o);
        end
    endtask

    // Monitor: one prediction per clock edge, compared just after the edge.
    initial begin
        out_t o;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                o = exp_q.pop_front();
                pops++;
                total++;
                if (anode_o !== o.anode || seg_o !== o.seg || dp_o !== o.dp ||
                    frame_o !== o.frame) begin
                    bad++;
                    $display("FAIL scan edge=%0d: got anode=%b seg=%b dp=%b frame=%b, want anode=%b seg=%b dp=%b frame=%b",
                             o.edge_no, anode_o, seg_o, dp_o, frame_o,
                             o.anode, o.seg, o.dp, o.frame);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] masks [5];
        masks[0] = 16'hFFFF;
        masks[1] = 16'h0FFF;
        masks[2] = 16'h00FF;
        masks[3] = 16'h000F;
        masks[4] = 16'h0000;

        // Reset state
        digits_i = 16'h1234;
        #23;
        check_reset("reset_hold");
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        // Plain decimal scan
        run(2 * FRAME);

        // Hex off: A blanks but stops LZB; then hex on
        digits_i = 16'h00A5; lzb_i = 1'b1; hex_mode_i = 1'b0;
        run(2 * FRAME);
        hex_mode_i = 1'b1;
        run(2 * FRAME);

        // All zero with LZB: only digit 0 lit
        digits_i = 16'h0000; hex_mode_i = 1'b0;
        run(2 * FRAME);

        // Mid-frame change must wait for the next frame
        digits_i = 16'h1111; lzb_i = 1'b0;
        run(FRAME + 9);
        digits_i = 16'h2222;
        run(FRAME + 23);

        // Decimal points, then disable mid-slot and re-enable
        dp_i = 4'b0101;
        run(FRAME + 3);
        en_i = 1'b0;
        run(FRAME + 7);
        en_i = 1'b1;
        run(FRAME);

        // Asynchronous reset mid-slot, then restart from digit 3
        push_expected();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        check_reset("reset_low");
        rst_n  = 1'b1;
        edge_n = 0;
        digits_i = 16'h9876; dp_i = 4'b1000;
        run(FRAME);

        // Blink on digit 0
        blink_i = 4'b0001;
        run(5 * FRAME);

        // Randomized inputs
        for (int i = 0; i < 24 * FRAME; i++) begin
            if ($urandom_range(0, 11) == 0) digits_i = 16'($urandom) & masks[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) dp_i = 4'($urandom);
            if ($urandom_range(0, 19) == 0) hex_mode_i = ~hex_mode_i;
            if ($urandom_range(0, 19) == 0) lzb_i = ~lzb_i;
            if ($urandom_range(0, 23) == 0) en_i = ~en_i;
            if ($urandom_range(0, 29) == 0) blink_i = 4'($urandom);
            run(1);
        end

        @(posedge clk);
        #2;
        total++;
        if (pops != pushes || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pops=%0d left=%0d, want pops=%0d left=0",
                     pops, exp_q.size(), pushes);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
